// File: rtl/dict_finder_pkg.sv
// Shared types for the dictionary finder: FSM states and entry-layout constants.
// Combinational definitions only; no latency and no flow control.
package dict_finder_pkg;

  typedef enum logic [3:0] {
    IDLE, LNK0, LNK1, LEN, CHK, RDN, RDT, CMP, RDOP, CAP, NEXT, DONE
  } finder_state_e;

  localparam logic [15:0] LINK_END = 16'hffff;
  localparam int          HDR_SZ   = 3;

endpackage

// File: rtl/dict_finder_byte_eq.sv
// Combinational byte compare with zero latency and no flow control.
// Define FINDER_NOCASE_EN to fold ASCII 'A'..'Z' to lower case on both operands.
module byte_eq #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

`ifdef FINDER_NOCASE_EN
  function automatic logic [W-1:0] fold(input logic [W-1:0] c);
    fold = c;
    if (c >= W'(8'h41) && c <= W'(8'h5a)) fold = c | W'(8'h20);
  endfunction

  assign eq = (fold(a) == fold(b));
`else
  assign eq = (a == b);
`endif

endmodule

// File: rtl/dict_finder.sv
// Walks the linked-list dictionary newest-first looking for the TIB token; 5 cycles per
// length-mismatch hop, 6+3n for an n-byte match. Sole bus master while busy; start ignored then.
module dict_finder
  import dict_finder_pkg::*;
#(
  parameter int ASZ      = 17,
  parameter int DSZ      = 8,
  parameter int MAX_HOPS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ASZ-1:0] ctx,
  input  logic [ASZ-1:0] tib,
  input  logic [7:0]     tlen,
  output logic           busy,
  output logic           done,
  output logic           hit,
  output logic           err,
  output logic [ASZ-1:0] lfa,
  output logic [ASZ-1:0] pfa,
  output logic [7:0]     op,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_ai,
  input  logic [DSZ-1:0] mem_vo
);

  localparam int HW = $clog2(MAX_HOPS + 1);

  finder_state_e  state, state_nxt;
  logic [ASZ-1:0] ent, tib_q, ai_q;
  logic [7:0]     tlen_q, idx;
  logic [DSZ-1:0] name_q;
  logic [15:0]    link;
  logic [HW-1:0]  hops;
  logic [HW-1:0]  hops_inc;
  logic           name_eq;
  logic           len_eq;

  assign mem_we   = 1'b0;
  assign hops_inc = hops + HW'(1);
  assign len_eq   = (mem_vo == DSZ'(tlen_q));

  byte_eq #(.W(DSZ)) u_byte_eq (
    .a  (mem_vo),
    .b  (name_q),
    .eq (name_eq)
  );

  // Address is driven only in the reading states; otherwise the last one is held.
  always_comb begin
    mem_ai = ai_q;
    case (state)
      LNK0:    mem_ai = ent;
      LNK1:    mem_ai = ent + ASZ'(1);
      LEN:     mem_ai = ent + ASZ'(2);
      RDN:     mem_ai = ent + ASZ'(HDR_SZ) + ASZ'(idx);
      RDT:     mem_ai = tib_q + ASZ'(idx);
      RDOP:    mem_ai = ent + ASZ'(HDR_SZ) + ASZ'(tlen_q);
      default: mem_ai = ai_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (tlen == 8'd0) ? DONE : LNK0;
      LNK0: state_nxt = LNK1;
      LNK1: state_nxt = LEN;
      LEN:  state_nxt = CHK;
      CHK:  state_nxt = len_eq ? RDN : NEXT;
      RDN:  state_nxt = RDT;
      RDT:  state_nxt = CMP;
      CMP: begin
        if (!name_eq)                   state_nxt = NEXT;
        else if (idx == tlen_q - 8'd1)  state_nxt = RDOP;
        else                            state_nxt = RDN;
      end
      RDOP: state_nxt = CAP;
      CAP:  state_nxt = DONE;
      NEXT: begin
        if (link == LINK_END || hops_inc == HW'(MAX_HOPS)) state_nxt = DONE;
        else                                               state_nxt = LNK0;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_q   <= '0;
      ent    <= '0;
      tib_q  <= '0;
      tlen_q <= '0;
      idx    <= '0;
      name_q <= '0;
      link   <= '0;
      hops   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hit    <= 1'b0;
      err    <= 1'b0;
      lfa    <= '0;
      pfa    <= '0;
      op     <= '0;
    end else begin
      ai_q <= mem_ai;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ent    <= ctx;
          tib_q  <= tib;
          tlen_q <= tlen;
          hops   <= '0;
          busy   <= 1'b1;
          hit    <= 1'b0;
          err    <= 1'b0;
        end
        LNK1: link[7:0]  <= 8'(mem_vo);
        LEN:  link[15:8] <= 8'(mem_vo);
        CHK:  idx        <= '0;
        RDT:  name_q     <= mem_vo;
        CMP:  if (name_eq) idx <= idx + 8'd1;
        CAP: begin
          op  <= 8'(mem_vo);
          lfa <= ent;
          pfa <= ent + ASZ'(HDR_SZ) + ASZ'(tlen_q);
          hit <= 1'b1;
        end
        NEXT: begin
          hops <= hops_inc;
          if (link != LINK_END) begin
            if (hops_inc == HW'(MAX_HOPS)) err <= 1'b1;
            else                           ent <= ASZ'(link);
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_finder.sv
// Bench for dict_finder: reference dictionary in a one-cycle-latency memory, walked by a
// list-level model; one DUT with the default hop limit and one with MAX_HOPS=4.
module tb_dict_finder;

  localparam int ASZ = 17;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]     start;
  logic [ASZ-1:0] ctx, tib;
  logic [7:0]     tlen;
  wire  [1:0]     busy, done, hit, err, we;
  wire  [ASZ-1:0] lfa [2];
  wire  [ASZ-1:0] pfa [2];
  wire  [ASZ-1:0] ai  [2];
  wire  [7:0]     op  [2];
  logic [7:0]     vo  [2];
  logic [7:0]     mem [0:511];

  dict_finder u_dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .ctx(ctx), .tib(tib), .tlen(tlen),
    .busy(busy[0]), .done(done[0]), .hit(hit[0]), .err(err[0]), .lfa(lfa[0]),
    .pfa(pfa[0]), .op(op[0]), .mem_we(we[0]), .mem_ai(ai[0]), .mem_vo(vo[0])
  );

  dict_finder #(.MAX_HOPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .ctx(ctx), .tib(tib), .tlen(tlen),
    .busy(busy[1]), .done(done[1]), .hit(hit[1]), .err(err[1]), .lfa(lfa[1]),
    .pfa(pfa[1]), .op(op[1]), .mem_we(we[1]), .mem_ai(ai[1]), .mem_vo(vo[1])
  );

  always @(posedge clk) begin
    vo[0] <= mem[ai[0][8:0]];
    vo[1] <= mem[ai[1][8:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef FINDER_NOCASE_EN
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  // Expected result and cycles from the start edge until done is seen.
  function automatic void model(input int c, input int t, input int n, input int maxh,
                                output bit h, output bit e, output int lf, output int pf,
                                output int o, output int lat);
    int ent, hops, cyc, len, link, j;
    h = 0; e = 0; lf = 0; pf = 0; o = 0;
    ent = c; hops = 0; cyc = 0;
    if (n == 0) begin
      lat = 2;
      return;
    end
    forever begin
      link = {mem[ent+1], mem[ent]};
      len  = mem[ent+2];
      cyc += 4;
      if (len == n) begin
        j = 0;
        while (j < n && fold(mem[ent+3+j]) == fold(mem[t+j])) j++;
        if (j == n) begin
          cyc += 3 * n + 2;
          h = 1; lf = ent; pf = ent + 3 + n; o = mem[ent+3+n];
          break;
        end
        cyc += 3 * (j + 1);
      end
      cyc += 1;
      hops++;
      if (link == 'hffff) break;
      if (hops == maxh) begin
        e = 1;
        break;
      end
      ent = link;
    end
    lat = cyc + 2;
  endfunction

  bit run_on = 0, fin = 0;
  int sel = 0, cnt = 0;
  bit e_hit, e_err;
  int e_lfa, e_pfa, e_op, e_lat;
  logic [ASZ-1:0] ai_snap;

  always @(negedge clk) begin
    if (run_on) begin
      cnt++;
      chk("mem_we", we[sel], 0);
      if (e_lat == 2) chk("no reads", ai[sel], ai_snap);
      if (cnt < e_lat) begin
        chk("busy", busy[sel], 1);
        chk("done early", done[sel], 0);
      end else if (cnt == e_lat) begin
        chk("done", done[sel], 1);
        chk("busy end", busy[sel], 0);
        chk("hit", hit[sel], e_hit);
        chk("err", err[sel], e_err);
        if (e_hit) begin
          chk("lfa", lfa[sel], e_lfa);
          chk("pfa", pfa[sel], e_pfa);
          chk("op", op[sel], e_op);
        end
      end else begin
        chk("done width", done[sel], 0);
        chk("hit hold", hit[sel], e_hit);
        run_on = 0;
        fin = 1;
      end
    end
  end

  task automatic search(input int s, input int c, input int t, input int n, input int maxh);
    model(c, t, n, maxh, e_hit, e_err, e_lfa, e_pfa, e_op, e_lat);
    @(posedge clk); #1;
    sel = s; ctx = c; tib = t; tlen = n; start[s] = 1'b1; ai_snap = ai[s];
    @(posedge clk); #1;
    start[s] = 1'b0; cnt = 0; fin = 0; run_on = 1;
    wait (fin);
  endtask

  task automatic run_vec(input string nm, input int s, input int t, input int n, input int maxh,
                         input bit lh, input bit le, input int llfa, input int lpfa,
                         input int lop, input int llat);
    search(s, 'h123, t, n, maxh);
    chk({nm, " model lat"}, e_lat, llat);
    chk({nm, " hit"}, hit[s], lh);
    chk({nm, " err"}, err[s], le);
    if (lh) begin
      chk({nm, " lfa"}, lfa[s], llfa);
      chk({nm, " pfa"}, pfa[s], lpfa);
      chk({nm, " op"}, op[s], lop);
    end
  endtask

  task automatic put_str(input int a, input string str);
    for (int i = 0; i < str.len(); i++) mem[a+i] = str[i];
  endtask

  task automatic put_entry(input int a, input int link, input string nm, input int o);
    mem[a]   = link[7:0];
    mem[a+1] = link[15:8];
    mem[a+2] = 8'(nm.len());
    put_str(a + 3, nm);
    mem[a+3+nm.len()] = o[7:0];
  endtask

  initial begin
    rst_n = 1'b0; start = 2'b00; ctx = '0; tib = '0; tlen = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    put_str(0, "123 456 +");
    put_str('h40, "nop");
    put_str('h50, "dro");
    put_str('h60, "SWAP");
    put_entry('h100, 'hffff, "nop",  'h01);
    put_entry('h107, 'h0100, "dup",  'h02);
    put_entry('h10e, 'h0107, "drop", 'h03);
    put_entry('h116, 'h010e, "swap", 'h04);
    put_entry('h11e, 'h0116, "+",    'h10);
    put_entry('h123, 'h011e, "-",    'h11);

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst busy", busy[k], 0);
      chk("rst done", done[k], 0);
      chk("rst hit", hit[k], 0);
      chk("rst err", err[k], 0);
      chk("rst lfa", lfa[k], 0);
      chk("rst op", op[k], 0);
      chk("rst ai", ai[k], 0);
    end
    rst_n = 1'b1;

    run_vec("plus", 0, 8, 1, 256, 1, 0, 'h11e, 'h122, 'h10, 19);
    run_vec("nop", 0, 'h40, 3, 256, 1, 0, 'h100, 'h106, 'h01, 45);
    run_vec("dro", 0, 'h50, 3, 256, 0, 0, 0, 0, 0, 41);
    run_vec("tlen0", 0, 0, 0, 256, 0, 0, 0, 0, 0, 2);
`ifdef FINDER_NOCASE_EN
    run_vec("SWAP", 0, 'h60, 4, 256, 1, 0, 'h116, 'h11d, 'h04, 30);
`else
    run_vec("SWAP", 0, 'h60, 4, 256, 0, 0, 0, 0, 0, 38);
`endif

    mem['h123] = 8'h23; mem['h124] = 8'h01;
    run_vec("selflink", 1, 8, 1, 4, 0, 1, 0, 0, 0, 34);
    mem['h123] = 8'h1e; mem['h124] = 8'h01;

    // Abort "nop" at the first name-byte read of "dup" (entry 0x107).
    @(posedge clk); #1;
    ctx = 'h123; tib = 'h40; tlen = 3; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    chk("rdn addr", ai[0], 'h10a);
    chk("rdn busy", busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy[0], 0);
    chk("abort lfa", lfa[0], 0);
    chk("abort ai", ai[0], 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort done", done[0], 0);
      chk("abort hit", hit[0], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst done", done[0], 0);
    run_vec("after rst", 0, 8, 1, 256, 1, 0, 'h11e, 'h122, 'h10, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
